multdiv_unit: RTL and testbench



---
 rtl/multdiv_unit.sv | 130 +++++++++++++
 tb/tb_multdiv_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed 32-bit shift-and-add multiply / restoring divide unit
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  // Largest product magnitudes that still fit a signed result of each sign.
  localparam logic [2*WIDTH-1:0] POS_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] NEG_MAX = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]   INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state;
  logic [CNT_W-1:0]     counter;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   rq;
  logic                 neg;
  logic                 is_div;
  logic                 div_zero;
  logic                 div_ovf;

  logic                 start;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [2*WIDTH-1:0]   rq_shift;
  logic [WIDTH:0]       div_diff;
  logic [WIDTH-1:0]     done_result;
  logic                 done_exc;
  logic                 last_step;

  // Operand magnitudes, one restoring-divide trial step, and the final sign/exception fixup.
  always_comb begin
    start     = ctrl_MULT ^ ctrl_DIV;
    abs_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    abs_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    rq_shift  = rq << 1;
    div_diff  = {1'b0, rq_shift[2*WIDTH-1:WIDTH]} - {1'b0, mag_b};
    last_step = (counter == CNT_W'(WIDTH - 1));
    done_result = '0;
    done_exc    = 1'b0;
    if (is_div) begin
      if (div_zero) begin
        done_result = '0;
        done_exc    = 1'b1;
      end else begin
        done_result = neg ? -rq[WIDTH-1:0] : rq[WIDTH-1:0];
        done_exc    = div_ovf;
      end
    end else begin
      done_result = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      done_exc    = neg ? (acc > NEG_MAX) : (acc > POS_MAX);
    end
  end

  // Control FSM and datapath registers; a valid start pulse restarts from any state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= '0;
      mag_b          <= '0;
      mplier         <= '0;
      mcand          <= '0;
      acc            <= '0;
      rq             <= '0;
      neg            <= 1'b0;
      is_div         <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else if (start) begin
      state          <= ctrl_DIV ? DIV : MULT;
      counter        <= '0;
      mag_b          <= abs_b;
      mplier         <= abs_b;
      mcand          <= {{WIDTH{1'b0}}, abs_a};
      acc            <= '0;
      rq             <= {{WIDTH{1'b0}}, abs_a};
      neg            <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      is_div         <= ctrl_DIV;
      div_zero       <= (data_operandB == '0);
      div_ovf        <= (data_operandA == INT_MIN) && (data_operandB == '1);
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        MULT: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          counter <= counter + 1'b1;
          if (last_step) state <= DONE;
        end
        DIV: begin
          if (!div_diff[WIDTH]) rq <= {div_diff[WIDTH-1:0], rq_shift[WIDTH-1:1], 1'b1};
          else                  rq <= rq_shift;
          counter <= counter + 1'b1;
          if (last_step) state <= DONE;
        end
        DONE: begin
          // First DONE edge publishes the result; the pulse edge after it returns to IDLE.
          if (!data_resultRDY) begin
            data_result    <= done_result;
            data_exception <= done_exc;
            data_resultRDY <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - directed self-checking bench for multdiv_unit
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int passed = 0;
  int total  = 0;
  int lat;
  int pulses;

  multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock),
    .reset(reset),
    .ctrl_MULT(ctrl_MULT),
    .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA),
    .data_operandB(data_operandB),
    .data_result(data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Drive a start pulse for one edge (E0); returns #1 after that edge.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT = m;
    ctrl_DIV  = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Count edges after the start edge until RDY is seen, bounded at 40.
  task automatic wait_rdy(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clock);
      n++;
      #1;
      if (data_resultRDY) break;
    end
  endtask

  // Count RDY pulses over a window of cycles.
  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) n++;
    end
  endtask

  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc);
    int n;
    start_op(m, d, a, b);
    wait_rdy(n);
    check({tag, "_latency"}, n, 33);
    check({tag, "_result"}, data_result, exp_res);
    check({tag, "_exception"}, {31'b0, data_exception}, {31'b0, exp_exc});
    @(posedge clock);
    #1;
    check({tag, "_rdy_single"}, {31'b0, data_resultRDY}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("reset_result", data_result, 32'd0);
    check("reset_exception", {31'b0, data_exception}, 32'd0);
    check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);

    run_op("mul_7_m6",      1, 0, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0);
    run_op("mul_ovf",       1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
    run_op("mul_intmin_1",  1, 0, 32'h80000000, 32'd1,        32'h80000000, 1'b0);
    run_op("mul_max_m1",    1, 0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0);
    run_op("div_m7_2",      0, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
    run_op("div_by_zero",   0, 1, 32'd100,      32'd0,        32'h00000000, 1'b1);
    run_op("div_intmin_m1", 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_op("div_zero_dvd",  0, 1, 32'd0,        32'd5,        32'h00000000, 1'b0);
    run_op("div_large",     0, 1, 32'h7FFFFFFF, 32'h10,       32'h07FFFFFF, 1'b0);

    // Restart: multiply aborted by a divide at E10.
    start_op(1, 0, 32'd3, 32'd5);
    count_pulses(9, pulses);
    check("restart_no_early_pulse", pulses, 0);
    start_op(0, 1, 32'd20, 32'd4);
    wait_rdy(lat);
    check("restart_latency", lat, 33);
    check("restart_result", data_result, 32'd5);
    count_pulses(10, pulses);
    check("restart_single_pulse", pulses, 0);

    // Both control lines at once are ignored.
    start_op(1, 1, 32'd9, 32'd9);
    count_pulses(40, pulses);
    check("both_ctrl_no_rdy", pulses, 0);
    check("both_ctrl_result_held", data_result, 32'd5);
    check("both_ctrl_exc_held", {31'b0, data_exception}, 32'd0);

    // Start held for three edges: restart each edge, one pulse 33 edges after the last.
    @(negedge clock);
    ctrl_MULT = 1'b1;
    data_operandA = 32'd2;
    data_operandB = 32'd3;
    repeat (3) @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    wait_rdy(lat);
    check("held_start_latency", lat, 33);
    check("held_start_result", data_result, 32'd6);

    // Reset at E20 of a divide.
    start_op(0, 1, 32'd1000, 32'd7);
    repeat (19) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midreset_result", data_result, 32'd0);
    check("midreset_exception", {31'b0, data_exception}, 32'd0);
    check("midreset_rdy", {31'b0, data_resultRDY}, 32'd0);
    count_pulses(40, pulses);
    check("midreset_no_rdy", pulses, 0);
    run_op("mul_m1_m1", 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
